// File: rtl/count_arbiter_pkg.sv
// Shared types and constants for count_arbiter.
// Optional build macro used by the top: COUNT_ARBITER_ABORT_EN.
package count_arbiter_pkg;

    localparam int N_REQ_DEF = 2;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Reset pointer sits on the last requester so the first search starts at requester 0.
    function automatic int rst_ptr(input int n_req);
        return n_req - 1;
    endfunction

endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic             valid
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;
    logic             take_s;

    // Walk the candidates in priority order; the first requester seen wins.
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        take_s  = 1'b0;
        idx_s   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s   = (idx_s == LAST_IDX) ? PTR_W'(0) : idx_s + PTR_W'(1);
            take_s  = req[idx_s] & ~found_s;
            win     = win | (take_s ? (ONE_HOT0 << idx_s) : N_REQ'(0));
            found_s = found_s | take_s;
        end
        valid = found_s;
    end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin owner of a shared up-counter: grants one requester, counts 0..len, pulses done.
// Build option: COUNT_ARBITER_ABORT_EN lets the owner abort a count by dropping req.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       cnt_out
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(rst_ptr(N_REQ));
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] win_s;
    logic             win_valid_s;
    logic [PTR_W-1:0] win_idx_s;
    logic [CNT_W-1:0] len_sel_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win_s),
        .valid (win_valid_s)
    );

    // Winner is one-hot, so OR-ing the masked candidates yields its index and len slice.
    always_comb begin
        win_idx_s = '0;
        len_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_idx_s = win_idx_s | (win_s[i] ? PTR_W'(i) : PTR_W'(0));
            len_sel_s = len_sel_s | (win_s[i] ? len[i*CNT_W +: CNT_W] : CNT_W'(0));
        end
    end

    // Next-state and next-output logic for the IDLE/COUNT/DONE controller.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (win_valid_s) begin
                    gnt_d   = win_s;
                    len_d   = len_sel_s;
                    cnt_d   = '0;
                    owner_d = win_idx_s;
                    state_d = COUNT;
                end else begin
                    gnt_d   = '0;
                end
            end
            COUNT: begin
`ifdef COUNT_ARBITER_ABORT_EN
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
`else
                if (cnt_q == len_q) begin
`endif
                    gnt_d   = '0;
                    done_d  = ONE_HOT0 << owner_q;
                    ptr_d   = owner_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed scoreboard bench for count_arbiter (N_REQ=2, CNT_W=4).
module tb_count_arbiter;

    localparam int N = 2;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cnt_out;

    count_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt_out (cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] done;
        logic         busy;
        logic [W-1:0] cnt;
    } obs_t;

    obs_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic expect_out(input logic [N-1:0] g, input logic [N-1:0] d,
                              input logic b, input logic [W-1:0] c);
        obs_t e;
        e.gnt  = g;
        e.done = d;
        e.busy = b;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    task automatic check(input string tag);
        obs_t e;
        obs_t o;
        o.gnt  = gnt;
        o.done = done;
        o.busy = busy;
        o.cnt  = cnt_out;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed output with no expected entry queued", tag);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s: observed gnt=%b done=%b busy=%b cnt=%0d, expected gnt=%b done=%b busy=%b cnt=%0d",
                       tag, o.gnt, o.done, o.busy, o.cnt, e.gnt, e.done, e.busy, e.cnt);
            end
        end
    endtask

    // Drive req for the coming edge, queue the post-edge expectation, then compare.
    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] d,
                        input logic b, input logic [W-1:0] c, input string tag);
        req = r;
        expect_out(g, d, b, c);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic set_len(input int i, input logic [W-1:0] v);
        len[i*W +: W] = v;
    endtask

    initial begin
        logic [N-1:0] w_oh;

        // Reset state
        #2;
        expect_out(2'b00, 2'b00, 1'b0, 4'd0);
        check("reset");
        #10 reset = 1'b0;
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd0, "idle_hold");

        // Single request, len=3
        set_len(0, 4'd3);
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd0, "t1_grant");
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd1, "t1_c1");
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd2, "t1_c2");
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd3, "t1_c3");
        tick(2'b01, 2'b00, 2'b01, 1'b1, 4'd3, "t1_done");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd3, "t1_busy_low");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd3, "t1_hold");

        // len=0
        set_len(0, 4'd0);
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd0, "t2_grant");
        tick(2'b01, 2'b00, 2'b01, 1'b1, 4'd0, "t2_done");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd0, "t2_idle");

        // Simultaneous requests straight out of reset
        reset = 1'b1;
        #1;
        expect_out(2'b00, 2'b00, 1'b0, 4'd0);
        check("t3_reset");
        #2 reset = 1'b0;
        set_len(0, 4'd2);
        set_len(1, 4'd2);
        tick(2'b11, 2'b01, 2'b00, 1'b1, 4'd0, "t3_g0");
        tick(2'b11, 2'b01, 2'b00, 1'b1, 4'd1, "t3_g0c1");
        tick(2'b11, 2'b01, 2'b00, 1'b1, 4'd2, "t3_g0c2");
        tick(2'b11, 2'b00, 2'b01, 1'b1, 4'd2, "t3_done0");
        tick(2'b10, 2'b00, 2'b00, 1'b0, 4'd2, "t3_idle");
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd0, "t3_g1");
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd1, "t3_g1c1");
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd2, "t3_g1c2");
        tick(2'b10, 2'b00, 2'b10, 1'b1, 4'd2, "t3_done1");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd2, "t3_end");

        // Both requesters re-raising after every done: grants alternate 0,1,0,1
        set_len(0, 4'd1);
        set_len(1, 4'd1);
        for (int r = 0; r < 4; r++) begin
            w_oh = (r % 2 == 0) ? 2'b01 : 2'b10;
            tick(2'b11, w_oh, 2'b00, 1'b1, 4'd0, "t4_grant");
            tick(2'b11, w_oh, 2'b00, 1'b1, 4'd1, "t4_c1");
            tick(2'b11, 2'b00, w_oh, 1'b1, 4'd1, "t4_done");
            tick(~w_oh, 2'b00, 2'b00, 1'b0, 4'd1, "t4_idle");
        end

        // Reset in the middle of a count
        set_len(0, 4'd5);
        set_len(1, 4'd0);
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd0, "t5_grant");
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd1, "t5_c1");
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd2, "t5_c2");
        #2 reset = 1'b1;
        #1;
        expect_out(2'b00, 2'b00, 1'b0, 4'd0);
        check("t5_async_reset");
        req = 2'b10;
        #2 reset = 1'b0;
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd0, "t5_g1_first");
        tick(2'b10, 2'b00, 2'b10, 1'b1, 4'd0, "t5_done1");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd0, "t5_idle");

        // Full-range terminal count: no wrap past 15
        set_len(0, 4'd15);
        for (int k = 0; k < 16; k++) begin
            tick(2'b01, 2'b01, 2'b00, 1'b1, k[W-1:0], "t6_count");
        end
        tick(2'b01, 2'b00, 2'b01, 1'b1, 4'd15, "t6_done");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd15, "t6_idle");

        // Owner drops req mid-count while requester 1 is pending
        set_len(0, 4'd7);
        set_len(1, 4'd3);
        tick(2'b01, 2'b01, 2'b00, 1'b1, 4'd0, "t7_grant");
        tick(2'b11, 2'b01, 2'b00, 1'b1, 4'd1, "t7_c1");
`ifdef COUNT_ARBITER_ABORT_EN
        tick(2'b10, 2'b00, 2'b00, 1'b0, 4'd1, "t7_abort");
`else
        set_len(0, 4'd2);
        for (int k = 2; k < 8; k++) begin
            tick(2'b10, 2'b01, 2'b00, 1'b1, k[W-1:0], "t7_cont");
        end
        tick(2'b10, 2'b00, 2'b01, 1'b1, 4'd7, "t7_done0");
        tick(2'b10, 2'b00, 2'b00, 1'b0, 4'd7, "t7_idle");
`endif
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd0, "t7_g1");
        set_len(1, 4'd0);
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd1, "t7_g1c1");
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd2, "t7_g1c2");
        tick(2'b10, 2'b10, 2'b00, 1'b1, 4'd3, "t7_g1c3");
        tick(2'b10, 2'b00, 2'b10, 1'b1, 4'd3, "t7_done1");
        tick(2'b00, 2'b00, 2'b00, 1'b0, 4'd3, "t7_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
